// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared encodings for the load/store bus initiator
// Contents: access-size codes, response error codes, FSM state type,
// bus address width and the misalignment rule shared by the initiator.
package bus_pkg;

  localparam int BUS_AW = 16;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Size 3 is reserved; it is reported as misaligned so it never reaches the bus.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] k);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return k[0];
      SZ_WORD: return |k;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/bus_lane_steer.sv
// rtl/bus_lane_steer.sv - byte-lane steering for stores and alignment/extension for loads
// Ports:
//   i_size     access size (byte/half/word)
//   i_k        byte offset within the word (addr[1:0])
//   i_wdata    right-justified store data
//   i_rdata    raw 32-bit bus read data
//   i_unsigned 1 = zero-extend loads, 0 = sign-extend
//   i_we       1 = store (enables byte strobes), 0 = load
//   o_we       byte write enables
//   o_dat_w    lane-replicated store data
//   o_rdata    aligned, extended load data
module bus_lane_steer
  import bus_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_k,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  input  logic        i_unsigned,
  input  logic        i_we,
  output logic [3:0]  o_we,
  output logic [31:0] o_dat_w,
  output logic [31:0] o_rdata
);

  // Only the low half of the shifted read word is ever needed for sub-word loads.
  logic [15:0] shifted;

  always_comb begin
    o_we    = 4'b0000;
    o_dat_w = i_wdata;
    o_rdata = i_rdata;
    shifted = 16'(i_rdata >> {i_k, 3'b000});
    case (i_size)
      SZ_BYTE: begin
        if (i_we) o_we = 4'b0001 << i_k;
        o_dat_w = {4{i_wdata[7:0]}};
        o_rdata = {{24{shifted[7] & ~i_unsigned}}, shifted[7:0]};
      end
      SZ_HALF: begin
        if (i_we) o_we = 4'b0011 << i_k;
        o_dat_w = {2{i_wdata[15:0]}};
        o_rdata = {{16{shifted[15] & ~i_unsigned}}, shifted[15:0]};
      end
      SZ_WORD: begin
        if (i_we) o_we = 4'b1111;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/bus_initiator.sv
// rtl/bus_initiator.sv - single-beat stb/ack load/store initiator with misalign check and ack timeout
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_req / o_req_ready  CPU request handshake (ready only in IDLE)
//   i_req_we/addr/size/unsigned/wdata  request fields, registered on accept
//   o_rsp_valid          one-cycle response pulse qualifying o_rsp_rdata/o_rsp_err
//   o_stb/o_addr/o_we/o_dat_w  bus strobe, word address, byte enables, write data
//   i_dat_r/i_ack        bus read data and acknowledge (ack may be combinational)
module bus_initiator
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [31:0]       i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic [1:0]        o_rsp_err,
  output logic              o_stb,
  output logic [BUS_AW-1:0] o_addr,
  output logic [3:0]        o_we,
  output logic [31:0]       o_dat_w,
  input  logic [31:0]       i_dat_r,
  input  logic              i_ack
);

  state_t              state_q, state_d;
  logic [1:0]          size_q, size_d;
  logic [1:0]          k_q, k_d;
  logic                unsigned_q, unsigned_d;
  logic                store_q, store_d;
  logic                stb_q, stb_d;
  logic [BUS_AW-1:0]   addr_q, addr_d;
  logic [3:0]          we_q, we_d;
  logic [31:0]         dat_w_q, dat_w_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_err_q, rsp_err_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;

  logic [TO_W-1:0]     cnt_inc;
  logic [1:0]          st_size;
  logic [1:0]          st_k;
  logic                st_we;
  logic [3:0]          st_we_mask;
  logic [31:0]         st_dat_w;
  logic [31:0]         st_rdata;

  // The bus only decodes a 16-bit window; upper address bits are dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^i_req_addr[31:16];

  // In IDLE the steering unit sees the incoming request so lanes can be
  // registered on accept; afterwards it sees the held request so the
  // captured read data can be aligned on ack.
  assign st_size = (state_q == ST_IDLE) ? i_req_size      : size_q;
  assign st_k    = (state_q == ST_IDLE) ? i_req_addr[1:0] : k_q;
  assign st_we   = (state_q == ST_IDLE) ? i_req_we        : store_q;

  bus_lane_steer u_steer (
    .i_size     (st_size),
    .i_k        (st_k),
    .i_wdata    (i_req_wdata),
    .i_rdata    (i_dat_r),
    .i_unsigned (unsigned_q),
    .i_we       (st_we),
    .o_we       (st_we_mask),
    .o_dat_w    (st_dat_w),
    .o_rdata    (st_rdata)
  );

  assign cnt_inc = cnt_q + TO_W'(1);

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    k_d         = k_q;
    unsigned_d  = unsigned_q;
    store_d     = store_q;
    stb_d       = stb_q;
    addr_d      = addr_q;
    we_d        = we_q;
    dat_w_d     = dat_w_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          size_d     = i_req_size;
          k_d        = i_req_addr[1:0];
          unsigned_d = i_req_unsigned;
          store_d    = i_req_we;
          if (is_misaligned(i_req_size, i_req_addr[1:0])) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_MISALIGN;
            rsp_rdata_d = 32'd0;
          end else begin
            state_d = ST_BUS;
            stb_d   = 1'b1;
            addr_d  = {i_req_addr[BUS_AW-1:2], 2'b00};
            we_d    = st_we_mask;
            dat_w_d = st_dat_w;
            cnt_d   = '0;
          end
        end
      end

      ST_BUS: begin
        // Ack is tested first so it wins over a coinciding timeout.
        if (i_ack) begin
          state_d     = ST_RESP;
          stb_d       = 1'b0;
          we_d        = 4'b0000;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_OK;
          rsp_rdata_d = store_q ? 32'd0 : st_rdata;
        end else if (cnt_inc == TO_W'(TIMEOUT_CYCLES)) begin
          state_d     = ST_RESP;
          stb_d       = 1'b0;
          we_d        = 4'b0000;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TIMEOUT;
          rsp_rdata_d = 32'd0;
          cnt_d       = cnt_inc;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        stb_d   = 1'b0;
        we_d    = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      size_q      <= SZ_BYTE;
      k_q         <= 2'd0;
      unsigned_q  <= 1'b0;
      store_q     <= 1'b0;
      stb_q       <= 1'b0;
      addr_q      <= '0;
      we_q        <= 4'b0000;
      dat_w_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= ERR_OK;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      k_q         <= k_d;
      unsigned_q  <= unsigned_d;
      store_q     <= store_d;
      stb_q       <= stb_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      dat_w_q     <= dat_w_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_req_ready = (state_q == ST_IDLE) && !i_rst;
  assign o_stb       = stb_q;
  assign o_addr      = addr_q;
  assign o_we        = we_q;
  assign o_dat_w     = dat_w_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_bus_initiator.sv
// tb/tb_bus_initiator.sv - self-checking bench for bus_initiator
module tb_bus_initiator;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        stb;
  logic [15:0] bus_addr;
  logic [3:0]  bus_we;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  int unsigned ack_delay;
  logic [31:0] bus_rdata;
  logic [3:0]  stb_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  bus_initiator #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_size(req_size),
    .i_req_unsigned(req_uns), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_stb(stb), .o_addr(bus_addr), .o_we(bus_we), .o_dat_w(dat_w),
    .i_dat_r(dat_r), .i_ack(ack)
  );

  // Responder: acks after ack_delay strobe cycles (0 = combinational, large = never).
  always @(posedge clk or posedge rst) begin
    if (rst) stb_cnt <= 4'd0;
    else if (!stb) stb_cnt <= 4'd0;
    else stb_cnt <= stb_cnt + 4'd1;
  end
  assign ack   = stb && ({28'd0, stb_cnt} == ack_delay);
  assign dat_r = bus_rdata;

  // Reference model
  function automatic logic [31:0] model_load(input logic [31:0] word, input int k, input int size, input logic uns);
    logic [31:0] v;
    int bits;
    if (size == 2) return word;
    bits = (size == 0) ? 8 : 16;
    v = (word >> (8 * k)) & ((32'd1 << bits) - 32'd1);
    if (!uns && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
    return v;
  endfunction

  function automatic logic [3:0] model_we(input int k, input int size);
    if (size == 0) return 4'(1 << k);
    if (size == 1) return 4'(3 << k);
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_dat(input logic [31:0] w, input int size);
    if (size == 0) return (w & 32'hFF) * 32'h01010101;
    if (size == 1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic model_mis(input logic [31:0] a, input int size);
    if (size == 3) return 1'b1;
    if (size == 1) return (a % 2) != 0;
    if (size == 2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  // Drives one request and observes a fixed 10-cycle window after the accept edge.
  task automatic run_txn(input logic we, input logic [31:0] a, input logic [1:0] size, input logic uns,
                         input logic [31:0] wdata, output logic rdy0, output int stb_cycles,
                         output logic [15:0] s_addr, output logic [3:0] s_we, output logic [31:0] s_dat,
                         output logic stable, output int rsp_cnt, output int rsp_cyc,
                         output logic [31:0] r_data, output logic [1:0] r_err, output logic [9:0] rdy_trace);
    @(negedge clk);
    rdy0 = req_ready;
    req = 1'b1; req_we = we; req_addr = a; req_size = size; req_uns = uns; req_wdata = wdata;
    @(posedge clk);
    #1 req = 1'b0;
    stb_cycles = 0; stable = 1'b1; rsp_cnt = 0; rsp_cyc = 0; r_data = 32'hDEADDEAD; r_err = 2'd3;
    s_addr = 16'hFFFF; s_we = 4'hF; s_dat = 32'hFFFFFFFF; rdy_trace = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      rdy_trace[c-1] = req_ready;
      if (stb) begin
        if (stb_cycles == 0) begin
          s_addr = bus_addr; s_we = bus_we; s_dat = dat_w;
        end else if (bus_addr !== s_addr || bus_we !== s_we || dat_w !== s_dat) begin
          stable = 1'b0;
        end
        stb_cycles++;
      end
      if (rsp_valid) begin
        rsp_cnt++; rsp_cyc = c; r_data = rsp_rdata; r_err = rsp_err;
      end
    end
  endtask

  logic        o_rdy0, o_stable;
  int          o_stbn, o_rcnt, o_rcyc;
  logic [15:0] o_addr;
  logic [3:0]  o_we;
  logic [31:0] o_dat, o_rd;
  logic [1:0]  o_err;
  logic [9:0]  o_trace;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({stb, bus_we, bus_addr, dat_w, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got stb=%b we=%h addr=%h dat=%h v=%b rd=%h err=%0d want all zero",
                         stb, bus_we, bus_addr, dat_w, rsp_valid, rsp_rdata, rsp_err);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", req_ready); end
  endtask

  task automatic test_word_store();
    ack_delay = 0;
    run_txn(1'b1, 32'h4000, 2'd2, 1'b0, 32'h12345678, o_rdy0, o_stbn, o_addr, o_we, o_dat, o_stable, o_rcnt, o_rcyc, o_rd, o_err, o_trace);
    n_tests++; if (o_rdy0 !== 1'b1) begin n_fail++; $display("FAIL ws_ready got %b want 1", o_rdy0); end
    n_tests++; if (o_stbn != 1) begin n_fail++; $display("FAIL ws_stb_cycles got %0d want 1", o_stbn); end
    n_tests++; if (o_addr !== 16'h4000) begin n_fail++; $display("FAIL ws_addr got %h want 4000", o_addr); end
    n_tests++; if (o_we !== 4'b1111) begin n_fail++; $display("FAIL ws_we got %b want 1111", o_we); end
    n_tests++; if (o_dat !== 32'h12345678) begin n_fail++; $display("FAIL ws_dat got %h want 12345678", o_dat); end
    n_tests++; if (o_rcnt != 1 || o_rcyc != 2) begin n_fail++; $display("FAIL ws_rsp_timing got cnt=%0d cyc=%0d want cnt=1 cyc=2", o_rcnt, o_rcyc); end
    n_tests++; if (o_err !== 2'd0 || o_rd !== 32'd0) begin n_fail++; $display("FAIL ws_rsp got err=%0d rd=%h want err=0 rd=0", o_err, o_rd); end
    n_tests++; if (o_trace[2:0] !== 3'b100) begin n_fail++; $display("FAIL ws_ready_trace got %b want 100", o_trace[2:0]); end
  endtask

  task automatic test_byte_load();
    ack_delay = 0; bus_rdata = 32'h80AABBCC;
    run_txn(1'b0, 32'hBFFB, 2'd0, 1'b0, 32'h0, o_rdy0, o_stbn, o_addr, o_we, o_dat, o_stable, o_rcnt, o_rcyc, o_rd, o_err, o_trace);
    n_tests++; if (o_we !== 4'b0000) begin n_fail++; $display("FAIL bl_we got %b want 0000", o_we); end
    n_tests++; if (o_addr !== 16'hBFF8) begin n_fail++; $display("FAIL bl_addr got %h want bff8", o_addr); end
    n_tests++; if (o_rd !== 32'hFFFFFF80 || o_err !== 2'd0) begin n_fail++; $display("FAIL bl_signed got rd=%h err=%0d want ffffff80 err=0", o_rd, o_err); end
    run_txn(1'b0, 32'hBFFB, 2'd0, 1'b1, 32'h0, o_rdy0, o_stbn, o_addr, o_we, o_dat, o_stable, o_rcnt, o_rcyc, o_rd, o_err, o_trace);
    n_tests++; if (o_rd !== 32'h00000080) begin n_fail++; $display("FAIL bl_unsigned got %h want 00000080", o_rd); end
  endtask

  task automatic test_half();
    ack_delay = 0;
    run_txn(1'b1, 32'h0002, 2'd1, 1'b0, 32'h0000BEEF, o_rdy0, o_stbn, o_addr, o_we, o_dat, o_stable, o_rcnt, o_rcyc, o_rd, o_err, o_trace);
    n_tests++; if (o_we !== 4'b1100) begin n_fail++; $display("FAIL hs_we got %b want 1100", o_we); end
    n_tests++; if (o_dat !== 32'hBEEFBEEF) begin n_fail++; $display("FAIL hs_dat got %h want beefbeef", o_dat); end
    bus_rdata = 32'hBEEF0001;
    run_txn(1'b0, 32'h0002, 2'd1, 1'b1, 32'h0, o_rdy0, o_stbn, o_addr, o_we, o_dat, o_stable, o_rcnt, o_rcyc, o_rd, o_err, o_trace);
    n_tests++; if (o_rd !== 32'h0000BEEF) begin n_fail++; $display("FAIL hl_rdata got %h want 0000beef", o_rd); end
  endtask

  task automatic test_misaligned();
    ack_delay = 0; bus_rdata = 32'h11223344;
    run_txn(1'b0, 32'h4006, 2'd2, 1'b0, 32'h0, o_rdy0, o_stbn, o_addr, o_we, o_dat, o_stable, o_rcnt, o_rcyc, o_rd, o_err, o_trace);
    n_tests++; if (o_stbn != 0) begin n_fail++; $display("FAIL mis_stb got %0d cycles want 0", o_stbn); end
    n_tests++; if (o_rcnt != 1 || o_rcyc != 1) begin n_fail++; $display("FAIL mis_timing got cnt=%0d cyc=%0d want cnt=1 cyc=1", o_rcnt, o_rcyc); end
    n_tests++; if (o_err !== 2'd1 || o_rd !== 32'd0) begin n_fail++; $display("FAIL mis_rsp got err=%0d rd=%h want err=1 rd=0", o_err, o_rd); end
  endtask

  task automatic test_timeout();
    bus_rdata = 32'hCAFEF00D;
    ack_delay = 15;
    run_txn(1'b0, 32'h0100, 2'd2, 1'b0, 32'h0, o_rdy0, o_stbn, o_addr, o_we, o_dat, o_stable, o_rcnt, o_rcyc, o_rd, o_err, o_trace);
    n_tests++; if (o_stbn != TO) begin n_fail++; $display("FAIL to_stb got %0d cycles want %0d", o_stbn, TO); end
    n_tests++; if (o_rcnt != 1 || o_rcyc != TO + 1) begin n_fail++; $display("FAIL to_timing got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", o_rcnt, o_rcyc, TO + 1); end
    n_tests++; if (o_err !== 2'd2 || o_rd !== 32'd0) begin n_fail++; $display("FAIL to_rsp got err=%0d rd=%h want err=2 rd=0", o_err, o_rd); end
    ack_delay = 0;
    run_txn(1'b0, 32'h0100, 2'd2, 1'b0, 32'h0, o_rdy0, o_stbn, o_addr, o_we, o_dat, o_stable, o_rcnt, o_rcyc, o_rd, o_err, o_trace);
    n_tests++; if (o_rdy0 !== 1'b1 || o_err !== 2'd0 || o_rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL to_recover got rdy=%b err=%0d rd=%h want rdy=1 err=0 rd=cafef00d", o_rdy0, o_err, o_rd); end
  endtask

  task automatic test_reset_mid_bus();
    int vcnt;
    logic stb_after;
    ack_delay = 3; bus_rdata = 32'h5A5A1234;
    @(negedge clk);
    req = 1'b1; req_we = 1'b0; req_addr = 32'h0020; req_size = 2'd2; req_uns = 1'b0;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    n_tests++; if (stb !== 1'b1) begin n_fail++; $display("FAIL rb_stb_before got %b want 1", stb); end
    #2 rst = 1'b1;
    #1 stb_after = stb;
    n_tests++; if (stb_after !== 1'b0) begin n_fail++; $display("FAIL rb_stb_async got %b want 0", stb_after); end
    vcnt = 0;
    repeat (2) begin @(negedge clk); if (rsp_valid) vcnt++; end
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rb_ready got %b want 1", req_ready); end
    repeat (5) begin if (rsp_valid || stb) vcnt++; @(negedge clk); end
    n_tests++; if (vcnt != 0) begin n_fail++; $display("FAIL rb_no_rsp got %0d stray cycles want 0", vcnt); end
    run_txn(1'b0, 32'h0020, 2'd2, 1'b0, 32'h0, o_rdy0, o_stbn, o_addr, o_we, o_dat, o_stable, o_rcnt, o_rcyc, o_rd, o_err, o_trace);
    n_tests++; if (o_stbn != 4 || o_rcyc != 5 || o_err !== 2'd0 || o_rd !== 32'h5A5A1234) begin
      n_fail++; $display("FAIL rb_after got stb=%0d cyc=%0d err=%0d rd=%h want 4 5 0 5a5a1234", o_stbn, o_rcyc, o_err, o_rd);
    end
  endtask

  task automatic test_random();
    logic        we, uns, mis;
    logic [31:0] a, wd;
    logic [1:0]  sz;
    int          pick, k, e_stb, e_cyc;
    logic [1:0]  e_err;
    logic [31:0] e_rd;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom); a = $urandom; wd = $urandom;
      bus_rdata = $urandom;
      pick = $urandom_range(0, 4);
      ack_delay = (pick == 4) ? 15 : pick;
      k = int'(a[1:0]);
      mis = model_mis(a, int'(sz));
      if (mis) begin
        e_stb = 0; e_cyc = 1; e_err = 2'd1; e_rd = 32'd0;
      end else if (ack_delay < TO) begin
        e_stb = ack_delay + 1; e_cyc = ack_delay + 2; e_err = 2'd0;
        e_rd = we ? 32'd0 : model_load(bus_rdata, k, int'(sz), uns);
      end else begin
        e_stb = TO; e_cyc = TO + 1; e_err = 2'd2; e_rd = 32'd0;
      end
      run_txn(we, a, sz, uns, wd, o_rdy0, o_stbn, o_addr, o_we, o_dat, o_stable, o_rcnt, o_rcyc, o_rd, o_err, o_trace);
      n_tests++; if (o_rdy0 !== 1'b1 || o_stbn != e_stb || o_rcnt != 1 || o_rcyc != e_cyc) begin
        n_fail++; $display("FAIL rnd%0d_timing got rdy=%b stb=%0d cnt=%0d cyc=%0d want 1 %0d 1 %0d", i, o_rdy0, o_stbn, o_rcnt, o_rcyc, e_stb, e_cyc);
      end
      n_tests++; if (o_err !== e_err || o_rd !== e_rd) begin
        n_fail++; $display("FAIL rnd%0d_rsp got err=%0d rd=%h want err=%0d rd=%h", i, o_err, o_rd, e_err, e_rd);
      end
      if (e_stb > 0) begin
        n_tests++; if (o_addr !== (a[15:0] & 16'hFFFC) || o_we !== (we ? model_we(k, int'(sz)) : 4'b0000) || !o_stable) begin
          n_fail++; $display("FAIL rnd%0d_bus got addr=%h we=%b stable=%b want addr=%h we=%b stable=1", i, o_addr, o_we, o_stable,
                             a[15:0] & 16'hFFFC, we ? model_we(k, int'(sz)) : 4'b0000);
        end
        if (we) begin
          n_tests++; if (o_dat !== model_dat(wd, int'(sz))) begin
            n_fail++; $display("FAIL rnd%0d_dat got %h want %h", i, o_dat, model_dat(wd, int'(sz)));
          end
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_size = 2'd0; req_uns = 1'b0;
    req_wdata = 32'd0; ack_delay = 0; bus_rdata = 32'd0;
    test_reset();
    test_word_store();
    test_byte_load();
    test_half();
    test_misaligned();
    test_timeout();
    test_reset_mid_bus();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
